// File: rtl/dcache_write_buffer_if.sv
// Bundle of dcache-side and Data_mem-side signals around the posted-write buffer.
// slave = the buffer itself, master = whoever drives the cache and memory sides.
interface dcache_write_buffer_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic            c_wr_valid;
    logic            c_wr_ready;
    logic [AW-1:0]   c_wr_addr;
    logic [DW-1:0]   c_wr_data;
    logic [DW/8-1:0] c_wr_mask;
    logic            c_rd_en;
    logic [AW-1:0]   c_rd_addr;
    logic [DW-1:0]   c_rd_data;
    logic            c_rd_valid;
    logic            empty;
    logic            m_wren;
    logic            m_wr_ready;
    logic [AW-1:0]   m_wraddress;
    logic [DW-1:0]   m_write_data;
    logic [DW/8-1:0] m_wr_mask;
    logic            m_rden;
    logic [AW-1:0]   m_rdaddress;
    logic [DW-1:0]   m_read_data;

    modport slave (
        input  c_wr_valid, c_wr_addr, c_wr_data, c_wr_mask, c_rd_en, c_rd_addr,
               m_wr_ready, m_read_data,
        output c_wr_ready, c_rd_data, c_rd_valid, empty, m_wren, m_wraddress,
               m_write_data, m_wr_mask, m_rden, m_rdaddress
    );

    modport master (
        output c_wr_valid, c_wr_addr, c_wr_data, c_wr_mask, c_rd_en, c_rd_addr,
               m_wr_ready, m_read_data,
        input  c_wr_ready, c_rd_data, c_rd_valid, empty, m_wren, m_wraddress,
               m_write_data, m_wr_mask, m_rden, m_rdaddress
    );
endinterface

// File: rtl/dcache_write_buffer.sv
// Posted-write FIFO between dcache and Data_mem: in-order drain, per-byte
// coalescing of same-address writes, and byte forwarding onto dcache reads.
module dcache_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 32
) (
    input  logic                clk,
    input  logic                rst,
    dcache_write_buffer_if.slave bus
);
    localparam int NB = DW / 8;
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    logic [AW-1:0]    r_addr [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [NB-1:0]    r_mask [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [PW:0]      r_count;
    logic [DW-1:0]    r_snap_data;
    logic [NB-1:0]    r_snap_mask;
    logic             r_rd_valid;

    logic             w_pop;
    logic             w_hit;
    logic [PW-1:0]    w_hit_idx;
    logic             w_accept;
    logic             w_wr_en;
    logic             w_push;
    logic [DW-1:0]    w_merged;
    logic [DW-1:0]    w_fwd_data;
    logic [NB-1:0]    w_fwd_mask;
    logic [DW-1:0]    w_rd_data;

    assign w_pop = (r_count != '0) && bus.m_wr_ready;

    // The head leaving this cycle cannot absorb a write; it would be lost.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_addr[i] == bus.c_wr_addr) &&
                !(w_pop && (r_head == PW'(i)))) begin
                w_hit     = 1'b1;
                w_hit_idx = PW'(i);
            end
        end
    end

    // Forwarding sees pre-write contents, including a head popped this cycle.
    always_comb begin
        w_fwd_data = '0;
        w_fwd_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_addr[i] == bus.c_rd_addr)) begin
                w_fwd_data = r_data[i];
                w_fwd_mask = r_mask[i];
            end
        end
    end

    always_comb begin
        w_merged = r_data[w_hit_idx];
        for (int b = 0; b < NB; b++) begin
            if (bus.c_wr_mask[b]) begin
                w_merged[b*8 +: 8] = bus.c_wr_data[b*8 +: 8];
            end
        end
    end

    assign bus.c_wr_ready = (r_count < FULL) || w_hit;
    assign w_accept       = bus.c_wr_valid && bus.c_wr_ready;
    assign w_wr_en        = w_accept && (bus.c_wr_mask != '0);
    assign w_push         = w_wr_en && !w_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_snap_data <= '0;
            r_snap_mask <= '0;
            r_rd_valid  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
                r_mask[i] <= '0;
            end
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_wr_en && w_hit) begin
                r_data[w_hit_idx] <= w_merged;
                r_mask[w_hit_idx] <= r_mask[w_hit_idx] | bus.c_wr_mask;
            end
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_addr[r_tail]  <= bus.c_wr_addr;
                r_data[r_tail]  <= bus.c_wr_data;
                r_mask[r_tail]  <= bus.c_wr_mask;
                r_tail          <= r_tail + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_rd_valid <= bus.c_rd_en;
            if (bus.c_rd_en) begin
                r_snap_data <= w_fwd_data;
                r_snap_mask <= w_fwd_mask;
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        if (r_rd_valid) begin
            for (int b = 0; b < NB; b++) begin
                w_rd_data[b*8 +: 8] = r_snap_mask[b] ? r_snap_data[b*8 +: 8]
                                                     : bus.m_read_data[b*8 +: 8];
            end
        end
    end

    assign bus.c_rd_data    = w_rd_data;
    assign bus.c_rd_valid   = r_rd_valid;
    assign bus.empty        = (r_count == '0);
    assign bus.m_wren       = (r_count != '0);
    assign bus.m_wraddress  = r_addr[r_head];
    assign bus.m_write_data = r_data[r_head];
    assign bus.m_wr_mask    = r_mask[r_head];
    assign bus.m_rden       = bus.c_rd_en;
    assign bus.m_rdaddress  = bus.c_rd_addr;
endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed bench for dcache_write_buffer: one-cycle vector table with
// hand-computed expectations, then wrap and mid-queue reset sequences.
module tb_dcache_write_buffer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_write_buffer_if #(.AW(16), .DW(32)) bus ();

    dcache_write_buffer #(.DEPTH(4), .AW(16), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        wv;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic        mrdy;
        logic        rde;
        logic [15:0] rda;
        logic [31:0] mrd;
        logic        e_rdy;
        logic        e_empty;
        logic        e_wren;
        logic [15:0] e_waddr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wmask;
        logic        e_rvalid;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[$];
    vec_t t;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input logic wv, input logic [15:0] addr, input logic [31:0] data,
                         input logic [3:0] mask, input logic mrdy, input logic rde,
                         input logic [15:0] rda, input logic [31:0] mrd);
        bus.c_wr_valid  = wv;
        bus.c_wr_addr   = addr;
        bus.c_wr_data   = data;
        bus.c_wr_mask   = mask;
        bus.m_wr_ready  = mrdy;
        bus.c_rd_en     = rde;
        bus.c_rd_addr   = rda;
        bus.m_read_data = mrd;
    endtask

    task automatic add(input logic wv, input logic [15:0] addr, input logic [31:0] data,
                       input logic [3:0] mask, input logic mrdy, input logic rde,
                       input logic [15:0] rda, input logic [31:0] mrd,
                       input logic rdy, input logic emp, input logic wren,
                       input logic [15:0] waddr, input logic [31:0] wdata,
                       input logic [3:0] wmask, input logic rv, input logic [31:0] rdat);
        vec_t v;
        v = '{wv, addr, data, mask, mrdy, rde, rda, mrd,
              rdy, emp, wren, waddr, wdata, wmask, rv, rdat};
        vecs.push_back(v);
    endtask

    initial begin
        //   wv addr      data          mask mr re rda       mrd           | rdy emp wren waddr     wdata         wmask rv rdata
        add(0, 16'h0000, 32'h00000000, 4'h0, 0, 0, 16'h0000, 32'h00000000, 1, 1, 0, 16'h0000, 32'h00000000, 4'h0, 0, 32'h00000000);
        add(1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 0, 16'h0000, 32'h00000000, 1, 1, 0, 16'h0000, 32'h00000000, 4'h0, 0, 32'h00000000);
        add(0, 16'h0000, 32'h00000000, 4'h0, 0, 0, 16'h0000, 32'h00000000, 1, 0, 1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 32'h00000000);
        add(1, 16'h0014, 32'h00000001, 4'hF, 0, 0, 16'h0000, 32'h00000000, 1, 0, 1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 32'h00000000);
        add(1, 16'h0018, 32'h00000002, 4'hF, 0, 0, 16'h0000, 32'h00000000, 1, 0, 1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 32'h00000000);
        add(1, 16'h001C, 32'h00000003, 4'hF, 0, 0, 16'h0000, 32'h00000000, 1, 0, 1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 32'h00000000);
        add(1, 16'h0024, 32'h00000004, 4'hF, 0, 0, 16'h0000, 32'h00000000, 0, 0, 1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 32'h00000000);
        add(1, 16'h0014, 32'h55000000, 4'h8, 0, 0, 16'h0000, 32'h00000000, 1, 0, 1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 32'h00000000);
        add(0, 16'h0000, 32'h00000000, 4'h0, 1, 0, 16'h0000, 32'h00000000, 0, 0, 1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 32'h00000000);
        add(0, 16'h0000, 32'h00000000, 4'h0, 1, 0, 16'h0000, 32'h00000000, 1, 0, 1, 16'h0014, 32'h55000001, 4'hF, 0, 32'h00000000);
        add(0, 16'h0000, 32'h00000000, 4'h0, 1, 0, 16'h0000, 32'h00000000, 1, 0, 1, 16'h0018, 32'h00000002, 4'hF, 0, 32'h00000000);
        add(0, 16'h0000, 32'h00000000, 4'h0, 1, 0, 16'h0000, 32'h00000000, 1, 0, 1, 16'h001C, 32'h00000003, 4'hF, 0, 32'h00000000);
        add(0, 16'h0000, 32'h00000000, 4'h0, 0, 0, 16'h0000, 32'h00000000, 1, 1, 0, 16'h0000, 32'h00000000, 4'h0, 0, 32'h00000000);
        add(1, 16'h0020, 32'h11223344, 4'h3, 0, 0, 16'h0000, 32'h00000000, 1, 1, 0, 16'h0000, 32'h00000000, 4'h0, 0, 32'h00000000);
        add(1, 16'h0020, 32'hAABBCCDD, 4'hC, 0, 0, 16'h0000, 32'h00000000, 1, 0, 1, 16'h0020, 32'h11223344, 4'h3, 0, 32'h00000000);
        add(0, 16'h0000, 32'h00000000, 4'h0, 0, 0, 16'h0000, 32'h00000000, 1, 0, 1, 16'h0020, 32'hAABB3344, 4'hF, 0, 32'h00000000);
        add(0, 16'h0000, 32'h00000000, 4'h0, 1, 0, 16'h0000, 32'h00000000, 1, 0, 1, 16'h0020, 32'hAABB3344, 4'hF, 0, 32'h00000000);
        add(1, 16'h0030, 32'h000000EF, 4'h1, 0, 0, 16'h0000, 32'h00000000, 1, 1, 0, 16'h0000, 32'h00000000, 4'h0, 0, 32'h00000000);
        add(0, 16'h0000, 32'h00000000, 4'h0, 0, 1, 16'h0030, 32'h00000000, 1, 0, 1, 16'h0030, 32'h000000EF, 4'h1, 0, 32'h00000000);
        add(0, 16'h0000, 32'h00000000, 4'h0, 0, 0, 16'h0000, 32'h12345678, 1, 0, 1, 16'h0030, 32'h000000EF, 4'h1, 1, 32'h123456EF);
        add(0, 16'h0000, 32'h00000000, 4'h0, 0, 1, 16'h0040, 32'h00000000, 1, 0, 1, 16'h0030, 32'h000000EF, 4'h1, 0, 32'h00000000);
        add(0, 16'h0000, 32'h00000000, 4'h0, 0, 0, 16'h0000, 32'hCAFEF00D, 1, 0, 1, 16'h0030, 32'h000000EF, 4'h1, 1, 32'hCAFEF00D);
        add(1, 16'h0030, 32'h000000AB, 4'h1, 0, 1, 16'h0030, 32'h00000000, 1, 0, 1, 16'h0030, 32'h000000EF, 4'h1, 0, 32'h00000000);
        add(0, 16'h0000, 32'h00000000, 4'h0, 0, 0, 16'h0000, 32'h12345678, 1, 0, 1, 16'h0030, 32'h000000AB, 4'h1, 1, 32'h123456EF);
        add(0, 16'h0000, 32'h00000000, 4'h0, 1, 1, 16'h0030, 32'h00000000, 1, 0, 1, 16'h0030, 32'h000000AB, 4'h1, 0, 32'h00000000);
        add(0, 16'h0000, 32'h00000000, 4'h0, 0, 0, 16'h0000, 32'h12345678, 1, 1, 0, 16'h0000, 32'h00000000, 4'h0, 1, 32'h123456AB);
        add(1, 16'h0050, 32'hFFFFFFFF, 4'h0, 0, 0, 16'h0000, 32'h00000000, 1, 1, 0, 16'h0000, 32'h00000000, 4'h0, 0, 32'h00000000);
        add(0, 16'h0000, 32'h00000000, 4'h0, 0, 0, 16'h0000, 32'h00000000, 1, 1, 0, 16'h0000, 32'h00000000, 4'h0, 0, 32'h00000000);
        add(1, 16'h0060, 32'h11111111, 4'hF, 0, 0, 16'h0000, 32'h00000000, 1, 1, 0, 16'h0000, 32'h00000000, 4'h0, 0, 32'h00000000);
        add(1, 16'h0060, 32'h22222222, 4'hF, 1, 0, 16'h0000, 32'h00000000, 1, 0, 1, 16'h0060, 32'h11111111, 4'hF, 0, 32'h00000000);
        add(0, 16'h0000, 32'h00000000, 4'h0, 0, 0, 16'h0000, 32'h00000000, 1, 0, 1, 16'h0060, 32'h22222222, 4'hF, 0, 32'h00000000);
        add(0, 16'h0000, 32'h00000000, 4'h0, 1, 0, 16'h0000, 32'h00000000, 1, 0, 1, 16'h0060, 32'h22222222, 4'hF, 0, 32'h00000000);
        add(0, 16'h0000, 32'h00000000, 4'h0, 0, 0, 16'h0000, 32'h00000000, 1, 1, 0, 16'h0000, 32'h00000000, 4'h0, 0, 32'h00000000);

        rst = 1'b1;
        drive(0, 16'h0000, 32'h0, 4'h0, 0, 0, 16'h0000, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            t = vecs[i];
            drive(t.wv, t.addr, t.data, t.mask, t.mrdy, t.rde, t.rda, t.mrd);
            @(negedge clk);
            check($sformatf("v%0d c_wr_ready", i), {31'b0, bus.c_wr_ready}, {31'b0, t.e_rdy});
            check($sformatf("v%0d empty", i), {31'b0, bus.empty}, {31'b0, t.e_empty});
            check($sformatf("v%0d m_wren", i), {31'b0, bus.m_wren}, {31'b0, t.e_wren});
            check($sformatf("v%0d c_rd_valid", i), {31'b0, bus.c_rd_valid}, {31'b0, t.e_rvalid});
            check($sformatf("v%0d m_rden", i), {31'b0, bus.m_rden}, {31'b0, t.rde});
            check($sformatf("v%0d m_rdaddress", i), {16'b0, bus.m_rdaddress}, {16'b0, t.rda});
            if (t.e_wren) begin
                check($sformatf("v%0d m_wraddress", i), {16'b0, bus.m_wraddress}, {16'b0, t.e_waddr});
                check($sformatf("v%0d m_write_data", i), bus.m_write_data, t.e_wdata);
                check($sformatf("v%0d m_wr_mask", i), {28'b0, bus.m_wr_mask}, {28'b0, t.e_wmask});
            end
            if (t.e_rvalid || i == 0) begin
                check($sformatf("v%0d c_rd_data", i), bus.c_rd_data, t.e_rdata);
            end
            @(posedge clk);
            #1;
        end

        // Six push+pop cycles walk head and tail around the ring past the wrap.
        for (int k = 0; k < 7; k++) begin
            if (k < 6) drive(1, 16'h0100 + 16'(4 * k), 32'hA0 + 32'(k), 4'hF, 1, 0, 16'h0000, 32'h0);
            else       drive(0, 16'h0000, 32'h0, 4'h0, 1, 0, 16'h0000, 32'h0);
            @(negedge clk);
            if (k > 0) begin
                check($sformatf("wrap%0d m_wraddress", k), {16'b0, bus.m_wraddress},
                      {16'b0, 16'h0100 + 16'(4 * (k - 1))});
                check($sformatf("wrap%0d m_write_data", k), bus.m_write_data, 32'hA0 + 32'(k - 1));
                check($sformatf("wrap%0d m_wren", k), {31'b0, bus.m_wren}, 32'd1);
            end
            @(posedge clk);
            #1;
        end
        drive(0, 16'h0000, 32'h0, 4'h0, 0, 0, 16'h0000, 32'h0);
        @(negedge clk);
        check("wrap_end empty", {31'b0, bus.empty}, 32'd1);
        @(posedge clk);
        #1;

        // Reset with three entries queued discards them all.
        for (int k = 0; k < 3; k++) begin
            drive(1, 16'h0200 + 16'(4 * k), 32'hB0 + 32'(k), 4'hF, 0, 0, 16'h0000, 32'h0);
            @(posedge clk);
            #1;
        end
        drive(0, 16'h0000, 32'h0, 4'h0, 0, 0, 16'h0000, 32'h0);
        @(negedge clk);
        check("pre_rst empty", {31'b0, bus.empty}, 32'd0);
        check("pre_rst m_wraddress", {16'b0, bus.m_wraddress}, 32'h0200);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(0, 16'h0000, 32'h0, 4'h0, 0, 1, 16'h0200, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 16'h0000, 32'h0, 4'h0, 0, 0, 16'h0000, 32'h0);
        @(negedge clk);
        check("post_rst empty", {31'b0, bus.empty}, 32'd1);
        check("post_rst m_wren", {31'b0, bus.m_wren}, 32'd0);
        check("post_rst c_wr_ready", {31'b0, bus.c_wr_ready}, 32'd1);
        check("post_rst c_rd_valid", {31'b0, bus.c_rd_valid}, 32'd0);
        check("post_rst c_rd_data", bus.c_rd_data, 32'd0);
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
